// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port arbiter in front of the memory coupler's
//               transaction interface. Port 0 is the CPU coupler side and
//               port 1 is the DMA/debug loader. Only one transaction is in
//               flight at a time. A round-robin pointer breaks ties. A trigger
//               that the coupler never acknowledges is aborted with err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sysclk                 in   system clock, all state on rising edge
//   reset                  in   asynchronous active-high reset
//   pX_req/we/byte         in   request, 1=store/0=load, byte access
//   pX_addr/wdata          in   address and store data (32 bit)
//   pX_gnt                 out  one-cycle grant pulse, fields captured
//   pX_done                out  one-cycle completion pulse
//   rdata                  out  last completed load data
//   err                    out  with done: aborted by timeout
//   Store/Load_Trigger     out  one-cycle command pulses to the coupler
//   write_buffer_A/D       out  latched address / store data
//   write_buffer_is_byte   out  latched byte flag
//   st_busy/ld_busy        in   coupler busy flags
//   load_from_mem_data     in   coupler load data
// ============================================================================
module mem_port_arbiter #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_byte,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_byte,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_done,
    output logic        p1_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        Store_Trigger,
    output logic        Load_Trigger,
    output logic [31:0] write_buffer_A,
    output logic [31:0] write_buffer_D,
    output logic        write_buffer_is_byte,
    input  logic        st_busy,
    input  logic        ld_busy,
    input  logic [31:0] load_from_mem_data
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_END   = 2'd3
    } state_t;

    // Counter value in the final WAIT_START cycle before the abort.
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t            r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_p0_gnt;
    logic              r_p1_gnt;
    logic              r_p0_done;
    logic              r_p1_done;
    logic              r_err;
    logic              r_st_trig;
    logic              r_ld_trig;
    logic [31:0]       r_rdata;
    logic [31:0]       r_wb_a;
    logic [31:0]       r_wb_d;
    logic              r_wb_byte;

    logic              w_any_req;
    logic              w_pick;
    logic              w_busy;
    logic              w_done_now;

    assign w_any_req  = p0_req | p1_req;
    // On a tie the port that did not complete last wins.
    assign w_pick     = (p0_req & p1_req) ? ~r_last : p1_req;
    // Only the busy flag matching the transaction direction matters.
    assign w_busy     = r_we ? st_busy : ld_busy;
    // The IDLE cycle carrying a done pulse does not arbitrate, so a new
    // grant appears two cycles after done at the earliest.
    assign w_done_now = r_p0_done | r_p1_done;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            r_err     <= 1'b0;
            r_st_trig <= 1'b0;
            r_ld_trig <= 1'b0;
            r_rdata   <= '0;
            r_wb_a    <= '0;
            r_wb_d    <= '0;
            r_wb_byte <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_p0_gnt  <= 1'b0;
            r_p1_gnt  <= 1'b0;
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            r_err     <= 1'b0;
            r_st_trig <= 1'b0;
            r_ld_trig <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req && !w_done_now) begin
                        r_owner   <= w_pick;
                        r_we      <= w_pick ? p1_we    : p0_we;
                        r_wb_a    <= w_pick ? p1_addr  : p0_addr;
                        r_wb_d    <= w_pick ? p1_wdata : p0_wdata;
                        r_wb_byte <= w_pick ? p1_byte  : p0_byte;
                        r_p0_gnt  <= ~w_pick;
                        r_p1_gnt  <= w_pick;
                        r_state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_st_trig <= r_we;
                    r_ld_trig <= ~r_we;
                    r_cnt     <= '0;
                    r_state   <= S_WAIT_START;
                end

                S_WAIT_START: begin
                    if (w_busy) begin
                        r_state <= S_WAIT_END;
                    end else if (r_cnt == c_TO_LAST) begin
                        // Coupler never acknowledged: abort, rdata untouched.
                        r_p0_done <= ~r_owner;
                        r_p1_done <= r_owner;
                        r_err     <= 1'b1;
                        r_last    <= r_owner;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_WAIT_END: begin
                    if (!w_busy) begin
                        if (!r_we) begin
                            r_rdata <= load_from_mem_data;
                        end
                        r_p0_done <= ~r_owner;
                        r_p1_done <= r_owner;
                        r_last    <= r_owner;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_gnt               = r_p0_gnt;
    assign p1_gnt               = r_p1_gnt;
    assign p0_done              = r_p0_done;
    assign p1_done              = r_p1_done;
    assign err                  = r_err;
    assign Store_Trigger        = r_st_trig;
    assign Load_Trigger         = r_ld_trig;
    assign rdata                = r_rdata;
    assign write_buffer_A       = r_wb_a;
    assign write_buffer_D       = r_wb_d;
    assign write_buffer_is_byte = r_wb_byte;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory-coupler transaction interface between two requesters: port 0 (CPU coupler side) and port 1 (DMA/debug loader).
- Sits between the requesters and the memory coupler's Store_Trigger/Load_Trigger, write-buffer and load-return signals.
- Serialises accesses with a round-robin grant and a one-transaction-in-flight FSM.
- Reports a timeout error if the coupler never acknowledges a trigger.

Parameters:
- ACK_TIMEOUT, 16: max cycles in WAIT_START for coupler busy to rise before the transaction is aborted with error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- sysclk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req, p1_req  in  1 each  request; held high until gnt.
- p0_we, p1_we  in  1 each  1=store, 0=load.
- p0_byte, p1_byte  in  1 each  byte access.
- p0_addr, p1_addr  in  32 each  address.
- p0_wdata, p1_wdata  in  32 each  store data.
- p0_gnt, p1_gnt  out  1 each  one-cycle grant pulse; request fields captured.
- p0_done, p1_done  out  1 each  one-cycle completion pulse.
- rdata  out  32  load data, valid with done of a load, held until next load completes.
- err  out  1  with done: transaction aborted by timeout.
- Store_Trigger, Load_Trigger  out  1 each  one-cycle pulses to coupler.
- write_buffer_A, write_buffer_D  out  32 each  latched address/data to coupler.
- write_buffer_is_byte  out  1  latched byte flag.
- st_busy, ld_busy  in  1 each  coupler busy flags.
- load_from_mem_data  in  32  coupler load data.

Behaviour:
- Reset (async, any state):
  - state=IDLE; all gnt/done/trigger/err=0.
  - rdata, write_buffer_A/D=0; write_buffer_is_byte=0.
  - rr pointer last=1, so port 0 wins first tie.
  - An in-flight coupler operation is abandoned; no done is issued.
- IDLE:
  - Only p0 req: choose 0. Only p1 req: choose 1.
  - Both: choose port != last.
  - On choice: latch addr/wdata/byte into write_buffer_* and we/owner into internal regs; pulse pX_gnt next cycle; go ISSUE.
  - req dropped before gnt: withdrawn, no effect.
- ISSUE (1 cycle): pulse Store_Trigger if we else Load_Trigger; clear timeout counter; go WAIT_START. Exactly one trigger per granted transaction.
- WAIT_START: watch st_busy (store) or ld_busy (load).
  - busy high: go WAIT_END.
  - Else counter++; counter reaching ACK_TIMEOUT: pulse owner done with err=1, rdata unchanged, go IDLE.
- WAIT_END: wait for the selected busy low.
  - Cycle it is first sampled low: for a load, rdata<=load_from_mem_data. Pulse owner done (err=0); set last=owner; go IDLE.
  - The opposite busy flag is ignored.
- Timeout also sets last=owner.
- Minimum transaction: req(T0) -> gnt(T1) -> trigger(T2) -> busy seen (T3) -> busy low (T4) -> done(T5).
- Back-to-back: new req evaluated in the IDLE cycle after done; gnt at done+2.
- write_buffer_* stable from ISSUE through done.
- err asserted only on the done cycle.
- gnt and done of the same port never coincide.

Test Plan:
- Reset mid-transaction: reset asserted during WAIT_END of p0 load -> gnt/done/triggers 0 immediately; next p1 req granted normally.
- Single store: p0_req, we=1, addr=0x100, wdata=0xDEADBEEF, byte=0; coupler raises st_busy 1 cycle after trigger, holds 3 cycles -> p0_gnt at T1, Store_Trigger at T2, write_buffer_A=0x100, D=0xDEADBEEF, p0_done at T7, err=0.
- Load return: p1 load addr=0x204, byte=1; coupler returns 0x000000A5 when ld_busy falls -> Load_Trigger only, write_buffer_is_byte=1, p1_done with rdata=0x000000A5.
- Round robin: p0 and p1 req simultaneously from reset, both held -> grant order 0,1,0,1 over four transactions; no port granted twice consecutively while the other waits.
- Timeout: p0 load, busy never rises, ACK_TIMEOUT=16 -> p0_done with err=1 exactly 16 cycles after WAIT_START entry; rdata unchanged; next req accepted.
- Withdrawn request: p1_req high 1 cycle while p0 transaction in WAIT_END, then low -> p1 never granted, no extra trigger.
